// File: rtl/cic_decimator_if.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator_if
// Purpose  : Complex sample stream (I/Q plus one-cycle Valid strobe) shared by
//            the CIC decimator input and output ports.
// Revision : 1.0 - initial release
// ============================================================================
interface cic_decimator_if;
    logic signed [17:0] I;
    logic signed [17:0] Q;
    logic               Valid;

    modport master (output I, output Q, output Valid);
    modport slave  (input  I, input  Q, input  Valid);
endinterface
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator
// Purpose  : N-stage complex CIC decimator, R = 2^k (k runtime selectable and
//            latched per output period), gain-normalised by a shift of N*k.
//            Optional macro CIC_ROUND_EN: round-half-up plus 18-bit saturation
//            on the output instead of plain truncation.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decimator #(
    parameter int N_STAGES      = 3,
    parameter int MAX_RATE_LOG2 = 6
) (
    input  wire logic        ipClk,
    input  wire logic        ipReset,
    cic_decimator_if.slave   ipInput,
    input  wire logic [2:0]  ipRateLog2,
    cic_decimator_if.master  opOutput
);

    localparam int         W     = 18 + N_STAGES * MAX_RATE_LOG2;
    localparam int         CW    = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;
    localparam int         SHW   = (N_STAGES * MAX_RATE_LOG2 > 0) ?
                                   $clog2(N_STAGES * MAX_RATE_LOG2 + 1) : 1;
    localparam logic [2:0] K_MAX = 3'(MAX_RATE_LOG2);

    // ------------------------------------------------------------------------
    // Shared control: phase counter, active k, decimation pipeline tags
    // ------------------------------------------------------------------------
    logic              started_q;
    logic [2:0]        k_act_q;
    logic [CW-1:0]     cnt_q;
    logic [N_STAGES:0] vld_q;
    logic [SHW-1:0]    sh_q [N_STAGES+1];
    logic              valid_q;

    logic [2:0]        w_k_in;
    logic [2:0]        w_k_cur;
    logic [CW-1:0]     w_last;
    logic              w_dec;
    logic [SHW-1:0]    w_sh_cur;

    // Before the first clock after reset release, k comes straight from the
    // port so that a sample on that very first edge already uses it.
    always_comb begin
        w_k_in   = (ipRateLog2 > K_MAX) ? K_MAX : ipRateLog2;
        w_k_cur  = started_q ? k_act_q : w_k_in;
        w_last   = ~({CW{1'b1}} << w_k_cur);
        w_dec    = ipInput.Valid && (cnt_q == w_last);
        w_sh_cur = SHW'(N_STAGES * int'(w_k_cur));
    end

    // Phase counting, k latching and alignment of the shift with each strobe.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            started_q <= 1'b0;
            k_act_q   <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            valid_q   <= 1'b0;
            for (int j = 0; j <= N_STAGES; j++) begin
                sh_q[j] <= '0;
            end
        end else begin
            started_q <= 1'b1;
            // The decimation point closes the period with the old k (already
            // captured into sh_q[0]); the new k governs the next period.
            if (!started_q || w_dec) begin
                k_act_q <= w_k_in;
            end
            if (ipInput.Valid) begin
                cnt_q <= w_dec ? '0 : cnt_q + 1'b1;
            end
            vld_q   <= {vld_q[N_STAGES-1:0], w_dec};
            sh_q[0] <= w_sh_cur;
            for (int j = 1; j <= N_STAGES; j++) begin
                sh_q[j] <= sh_q[j-1];
            end
            valid_q <= vld_q[N_STAGES];
        end
    end

    // ------------------------------------------------------------------------
    // Datapath, instantiated identically for I (p=0) and Q (p=1)
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_path
        logic signed [17:0]  w_in;
        logic signed [W-1:0] w_acc;
        logic signed [W-1:0] int_q  [N_STAGES];
        logic signed [W-1:0] int_d  [N_STAGES];
        logic signed [W-1:0] cin_d  [N_STAGES];
        logic signed [W-1:0] comb_q [N_STAGES];
        logic signed [W-1:0] dly_q  [N_STAGES];
        logic signed [17:0]  res_d;
        logic signed [17:0]  out_q;

        assign w_in = (p == 0) ? ipInput.I : ipInput.Q;

        // Integrator cascade settles in one cycle so the decimation-point
        // sample is already inside the last integrator when it is captured.
        always_comb begin
            w_acc = {{(W-18){w_in[17]}}, w_in};
            for (int n = 0; n < N_STAGES; n++) begin
                w_acc    = int_q[n] + w_acc;
                int_d[n] = w_acc;
            end
            cin_d[0] = int_q[N_STAGES-1];
            for (int j = 1; j < N_STAGES; j++) begin
                cin_d[j] = comb_q[j-1];
            end
        end

        // Integrators advance only on valid input samples, wrapping modulo 2^W.
        always_ff @(posedge ipClk or negedge ipReset) begin
            if (!ipReset) begin
                for (int n = 0; n < N_STAGES; n++) begin
                    int_q[n] <= '0;
                end
            end else if (ipInput.Valid) begin
                for (int n = 0; n < N_STAGES; n++) begin
                    int_q[n] <= int_d[n];
                end
            end
        end

        // Comb pipeline: each stage differences against its previous decimated input.
        always_ff @(posedge ipClk or negedge ipReset) begin
            if (!ipReset) begin
                for (int j = 0; j < N_STAGES; j++) begin
                    comb_q[j] <= '0;
                    dly_q[j]  <= '0;
                end
            end else begin
                for (int j = 0; j < N_STAGES; j++) begin
                    if (vld_q[j]) begin
                        comb_q[j] <= cin_d[j] - dly_q[j];
                        dly_q[j]  <= cin_d[j];
                    end
                end
            end
        end

`ifdef CIC_ROUND_EN
        localparam logic signed [W:0] SAT_MAX = (W+1)'(131071);
        localparam logic signed [W:0] SAT_MIN = -SAT_MAX - 1;
        logic signed [W:0] w_sum;
        logic signed [W:0] w_shd;

        // Round half up by adding half an LSB of the shifted result, then clip.
        always_comb begin
            w_sum = {comb_q[N_STAGES-1][W-1], comb_q[N_STAGES-1]};
            if (sh_q[N_STAGES] != '0) begin
                w_sum = w_sum + ((W+1)'(1) << (sh_q[N_STAGES] - 1'b1));
            end
            w_shd = w_sum >>> sh_q[N_STAGES];
            if (w_shd > SAT_MAX) begin
                res_d = 18'sh1FFFF;
            end else if (w_shd < SAT_MIN) begin
                res_d = 18'sh20000;
            end else begin
                res_d = w_shd[17:0];
            end
        end
`else
        // Truncating normalisation: arithmetic shift, keep the low 18 bits.
        always_comb begin
            res_d = 18'(comb_q[N_STAGES-1] >>> sh_q[N_STAGES]);
        end
`endif

        // Output sample register, held between strobes.
        always_ff @(posedge ipClk or negedge ipReset) begin
            if (!ipReset) begin
                out_q <= '0;
            end else if (vld_q[N_STAGES]) begin
                out_q <= res_d;
            end
        end
    end

    assign opOutput.I     = g_path[0].out_q;
    assign opOutput.Q     = g_path[1].out_q;
    assign opOutput.Valid = valid_q;

endmodule
`default_nettype wire

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter: N_STAGES, 3, number of integrator and comb stages (1..4).
REQ-002 Parameter: MAX_RATE_LOG2, 6, largest supported log2 decimation ratio.
REQ-003 Derived width: W = 18 + N_STAGES*MAX_RATE_LOG2 bits for all internal accumulators (36 at defaults).
REQ-004 Port: ipClk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: ipReset  in  1  asynchronous, active-low reset.
REQ-006 Port: ipInput  in  COMPLEX_STREAM  I, Q: 18-bit signed; Valid: 1-bit sample strobe; mixer output, one sample per Valid cycle.
REQ-007 Port: ipRateLog2  in  3  k; decimation ratio R = 2^k; values above MAX_RATE_LOG2 clamp to MAX_RATE_LOG2.
REQ-008 Port: opOutput  out  COMPLEX_STREAM  decimated I, Q: 18-bit signed; Valid: one-cycle strobe per output sample.

Function
REQ-009 I and Q paths shall be identical, independent, and updated in the same cycles.
REQ-010 Integrators: on each cycle with ipInput.Valid=1, stage 0 adds sign-extended input; stage n adds stage n-1 output; single-cycle update; no change when Valid=0.
REQ-011 Integrator and comb arithmetic: two's-complement W-bit, modular wrap; no saturation inside the filter.
REQ-012 Phase counter: counts valid inputs 0..R-1; the valid input taken with count = R-1 is the decimation point; count then returns to 0.
REQ-013 Active k: latched from ipRateLog2 at reset release and at each decimation point only; mid-period changes take effect next period.
REQ-014 Combs: at each decimation point the last integrator value enters a pipelined chain of N_STAGES combs; each stage computes x - x_prev (differential delay 1 at decimated rate); one register per stage.
REQ-015 Latency: opOutput.Valid high exactly N_STAGES+1 cycles after the cycle sampling the decimation-point input (4 cycles at defaults).
REQ-016 Throughput: accepts Valid on every cycle for any k including k=0; no input sample ever dropped or stalled.
REQ-017 Output scaling: comb result arithmetic-shifted right by N_STAGES*k, then bits [17:0] taken; DC gain exactly 1.
REQ-018 k=0 (R=1): output sequence equals input sequence, delayed per REQ-015.
REQ-019 opOutput.I/Q hold their value between strobes; Valid low except the strobe cycle.
REQ-020 Decimation point coinciding with active k change: the sample completing the period uses the old k for shift; the new period uses the new k.

Reset
REQ-021 ipReset=0 asynchronously clears integrators, comb delays, comb pipeline, phase counter, opOutput.I, opOutput.Q, opOutput.Valid to 0.
REQ-022 Reset asserted mid-period or with strobes in flight discards all pending outputs; no Valid strobe during or from before reset.
REQ-023 First valid input after release has phase count 0.

Configuration
REQ-024 Macro CIC_ROUND_EN defined: before the REQ-017 shift add 2^(N_STAGES*k-1) (none when k=0), round half up, saturate the 18-bit result to [-131072, 131071].
REQ-025 CIC_ROUND_EN undefined: plain truncating shift per REQ-017, no rounding adder, no saturation logic.

Verification
REQ-026 k=0, Valid every cycle, I=ramp 0,1,2..., Q=-ramp -> opOutput identical ramps, 4 cycles delayed, Valid every cycle.
REQ-027 k=2, DC I=1000, Q=-1000, Valid every cycle -> after first 3 outputs settle, every output I=1000, Q=-1000, one strobe per 4 inputs.
REQ-028 k=1, impulse I=4 as first valid sample after reset, then zeros -> outputs I=1,0 (undefined macro) or I=2,1 (CIC_ROUND_EN), then 0.
REQ-029 k=6, DC I=131071, Q=-131072, Valid 1-in-3 cycles -> settled outputs 131071/-131072, no wrap, strobe every 64 valid inputs.
REQ-030 ipRateLog2 changed 2->3 mid-period -> current period completes at 4 inputs, following periods 8 inputs, settled DC preserved.
REQ-031 Reset pulse 2 cycles after a decimation point -> no strobe emitted, outputs 0, next strobe after full R inputs post-release.
